// File: rtl/atm_fe_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, phase
// encoding and transaction codes.
package atm_fe_pkg;

   // Command keys; codes 0-9 are digits.
   localparam logic [3:0] KEY_ENTER    = 4'hA;
   localparam logic [3:0] KEY_CLEAR    = 4'hB;
   localparam logic [3:0] KEY_CANCEL   = 4'hC;
   localparam logic [3:0] KEY_WITHDRAW = 4'hD;
   localparam logic [3:0] KEY_BALANCE  = 4'hE;
   localparam logic [3:0] KEY_DEPOSIT  = 4'hF;

   // Session phase, exported as PHASE for the display.
   typedef enum logic [2:0] {
      PH_CARD      = 3'd0,
      PH_CARD_WAIT = 3'd1,
      PH_PIN       = 3'd2,
      PH_PIN_WAIT  = 3'd3,
      PH_TXN       = 3'd4,
      PH_AMT       = 3'd5,
      PH_TXN_WAIT  = 3'd6
   } phase_t;

   // Transaction codes presented on the ATM command bus.
   localparam logic [1:0] TXN_WITHDRAW = 2'b00;
   localparam logic [1:0] TXN_BALANCE  = 2'b01;
   localparam logic [1:0] TXN_DEPOSIT  = 2'b10;
   localparam logic [1:0] TXN_NONE     = 2'b11;

   function automatic logic is_digit(input logic [3:0] k);
      return (k <= 4'd9);
   endfunction

   function automatic logic [1:0] key_to_txn(input logic [3:0] k);
      case (k)
         KEY_WITHDRAW: return TXN_WITHDRAW;
         KEY_BALANCE:  return TXN_BALANCE;
         KEY_DEPOSIT:  return TXN_DEPOSIT;
         default:      return TXN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/atm_fe_dec_accum.sv
// Decimal entry accumulator: acc = acc*10 + digit, with a digit counter
// that saturates at MAX_DIGITS so the value cannot wrap.
module atm_fe_dec_accum
   import atm_fe_pkg::*;
#(
   parameter int MAX_DIGITS = 9,
   parameter int DATA_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              digit_vld,
   input  logic [3:0]        digit,
   output logic [DATA_W-1:0] acc,
   output logic              full
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

   logic [CNT_W-1:0] count;

   // Multiply by ten as shift-and-add, then add the new digit.
   function automatic logic [DATA_W-1:0] mac10(input logic [DATA_W-1:0] a,
                                                input logic [3:0] d);
      return (a << 3) + (a << 1) + DATA_W'(d);
   endfunction

   assign full = (count == CNT_MAX);

   // Accumulate digits until full; clear restarts the entry.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc   <= '0;
         count <= '0;
      end else if (digit_vld && !full) begin
         acc   <= mac10(acc, digit);
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad-to-ATM command sequencer: card -> PIN (with retries) ->
// transaction -> amount. Optional inactivity timeout is compiled in when
// the macro ATM_FE_TIMEOUT_EN is defined.
module atm_keypad_frontend
   import atm_fe_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 2,
   parameter int MAX_TRIES      = 3,
   parameter int MAX_DIGITS     = 9,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        KEY_VALID,
   input  logic [3:0]  KEY_CODE,
   input  logic        SUCCESS,
   input  logic [3:0]  STATUS,
   output logic [3:0]  CARD_ID,
   output logic [3:0]  PIN0,
   output logic [3:0]  PIN1,
   output logic [3:0]  PIN2,
   output logic [3:0]  PIN3,
   output logic [1:0]  TRANSACTION,
   output logic [31:0] AMOUNT,
   output logic        OKAY,
   output logic        CANCEL,
   output logic [2:0]  PHASE,
   output logic [1:0]  TRIES_LEFT,
   output logic        LAST_SUCCESS,
   output logic [3:0]  LAST_STATUS,
   output logic        ERROR
);

   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0] TRIES_INIT = 2'(MAX_TRIES);

   phase_t state, state_nxt;

   logic [SETTLE_W-1:0] settle_cnt;
   logic                settle_done;
   logic [3:0]          card_buf;
   logic                card_has;
   logic [3:0]          pin_buf [4];
   logic [2:0]          pin_cnt;
   logic [1:0]          txn_code;
   logic [31:0]         acc;
   logic                acc_full;
   logic                to_hit;

   logic key_digit, key_enter, key_clear, key_cancel, key_bal, key_amt_txn;

   // Action strobes produced by the sequencer.
   logic cancel_all, end_session, err;
   logic card_wr, card_clr, card_accept, capture;
   logic pin_wr, pin_clr, pin_accept, tries_reload, tries_dec;
   logic txn_bal, code_latch, acc_wr, acc_clr, amt_accept, txn_done;

   assign key_digit   = KEY_VALID && is_digit(KEY_CODE);
   assign key_enter   = KEY_VALID && (KEY_CODE == KEY_ENTER);
   assign key_clear   = KEY_VALID && (KEY_CODE == KEY_CLEAR);
   assign key_cancel  = KEY_VALID && (KEY_CODE == KEY_CANCEL);
   assign key_bal     = KEY_VALID && (KEY_CODE == KEY_BALANCE);
   assign key_amt_txn = KEY_VALID && ((KEY_CODE == KEY_WITHDRAW) || (KEY_CODE == KEY_DEPOSIT));

   assign settle_done = (settle_cnt == SETTLE_LAST);
   assign PHASE       = state;

`ifdef ATM_FE_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt;

   assign to_hit = (to_cnt == TO_LAST) && !KEY_VALID;

   // Inactivity counter: restarts on any key and on every phase change.
   always_ff @(posedge CLK) begin
      if (RESET || KEY_VALID || (state_nxt != state))
         to_cnt <= '0;
      else if (to_cnt != TO_LAST)
         to_cnt <= to_cnt + 1'b1;
   end
`else
   // Sessions never expire in this build; the limit is never reachable.
   assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Phase register and settle counter, restarted on each phase change.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= PH_CARD;
         settle_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            settle_cnt <= '0;
         else if (settle_cnt != SETTLE_LAST)
            settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // Next phase and action strobes; cancel/timeout outrank every key.
   always_comb begin
      state_nxt    = state;
      cancel_all   = 1'b0;
      end_session  = 1'b0;
      err          = 1'b0;
      card_wr      = 1'b0;
      card_clr     = 1'b0;
      card_accept  = 1'b0;
      capture      = 1'b0;
      pin_wr       = 1'b0;
      pin_clr      = 1'b0;
      pin_accept   = 1'b0;
      tries_reload = 1'b0;
      tries_dec    = 1'b0;
      txn_bal      = 1'b0;
      code_latch   = 1'b0;
      acc_wr       = 1'b0;
      acc_clr      = 1'b0;
      amt_accept   = 1'b0;
      txn_done     = 1'b0;
      if (to_hit && state != PH_CARD) begin
         cancel_all = 1'b1;
         err        = 1'b1;
         state_nxt  = PH_CARD;
      end else if (to_hit) begin
         card_clr = 1'b1;
      end else if (key_cancel && state != PH_CARD) begin
         cancel_all = 1'b1;
         state_nxt  = PH_CARD;
      end else begin
         case (state)
            PH_CARD: begin
               if (key_digit)
                  card_wr = 1'b1;
               else if (key_enter) begin
                  if (card_has) begin
                     card_accept = 1'b1;
                     state_nxt   = PH_CARD_WAIT;
                  end else
                     err = 1'b1;
               end else if (key_clear || key_cancel)
                  card_clr = 1'b1;
            end
            PH_CARD_WAIT: begin
               if (settle_done) begin
                  capture = 1'b1;
                  if (SUCCESS) begin
                     pin_clr   = 1'b1;
                     state_nxt = PH_PIN;
                  end else begin
                     end_session = 1'b1;
                     state_nxt   = PH_CARD;
                  end
               end
            end
            PH_PIN: begin
               if (key_digit) begin
                  if (pin_cnt < 3'd4)
                     pin_wr = 1'b1;
                  else
                     err = 1'b1;
               end else if (key_clear)
                  pin_clr = 1'b1;
               else if (key_enter) begin
                  if (pin_cnt == 3'd4) begin
                     pin_accept = 1'b1;
                     state_nxt  = PH_PIN_WAIT;
                  end else
                     err = 1'b1;
               end
            end
            PH_PIN_WAIT: begin
               if (settle_done) begin
                  capture = 1'b1;
                  if (SUCCESS) begin
                     tries_reload = 1'b1;
                     state_nxt    = PH_TXN;
                  end else begin
                     tries_dec = 1'b1;
                     if (TRIES_LEFT <= 2'd1) begin
                        end_session = 1'b1;
                        state_nxt   = PH_CARD;
                     end else begin
                        pin_clr   = 1'b1;
                        state_nxt = PH_PIN;
                     end
                  end
               end
            end
            PH_TXN: begin
               if (key_digit || key_enter)
                  err = 1'b1;
               else if (key_bal) begin
                  txn_bal   = 1'b1;
                  state_nxt = PH_TXN_WAIT;
               end else if (key_amt_txn) begin
                  code_latch = 1'b1;
                  state_nxt  = PH_AMT;
               end
            end
            PH_AMT: begin
               if (key_digit) begin
                  if (acc_full)
                     err = 1'b1;
                  else
                     acc_wr = 1'b1;
               end else if (key_clear)
                  acc_clr = 1'b1;
               else if (key_enter) begin
                  if (acc == '0)
                     err = 1'b1;
                  else begin
                     amt_accept = 1'b1;
                     acc_clr    = 1'b1;
                     state_nxt  = PH_TXN_WAIT;
                  end
               end
            end
            PH_TXN_WAIT: begin
               if (settle_done) begin
                  capture   = 1'b1;
                  txn_done  = 1'b1;
                  state_nxt = PH_TXN;
               end
            end
            default: state_nxt = PH_CARD;
         endcase
      end
   end

   atm_fe_dec_accum #(
      .MAX_DIGITS (MAX_DIGITS),
      .DATA_W     (32)
   ) u_accum (
      .clk       (CLK),
      .rst       (RESET),
      .clr       (acc_clr || cancel_all),
      .digit_vld (acc_wr),
      .digit     (KEY_CODE),
      .acc       (acc),
      .full      (acc_full)
   );

   // Entry buffers: card digit, PIN digits and the pending transaction code.
   always_ff @(posedge CLK) begin
      if (RESET || cancel_all || end_session) begin
         card_buf <= '0;
         card_has <= 1'b0;
         pin_cnt  <= '0;
         txn_code <= TXN_NONE;
         for (int i = 0; i < 4; i++) pin_buf[i] <= '0;
      end else begin
         if (card_wr) begin
            card_buf <= KEY_CODE;
            card_has <= 1'b1;
         end else if (card_clr) begin
            card_buf <= '0;
            card_has <= 1'b0;
         end
         if (pin_clr || pin_accept) begin
            pin_cnt <= '0;
            for (int i = 0; i < 4; i++) pin_buf[i] <= '0;
         end else if (pin_wr) begin
            pin_buf[pin_cnt[1:0]] <= KEY_CODE;
            pin_cnt               <= pin_cnt + 1'b1;
         end
         if (code_latch)
            txn_code <= key_to_txn(KEY_CODE);
      end
   end

   // Command bus and status outputs towards the ATM and the display.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         CARD_ID      <= '0;
         PIN0         <= '0;
         PIN1         <= '0;
         PIN2         <= '0;
         PIN3         <= '0;
         TRANSACTION  <= TXN_NONE;
         AMOUNT       <= '0;
         OKAY         <= 1'b0;
         CANCEL       <= 1'b0;
         TRIES_LEFT   <= TRIES_INIT;
         LAST_SUCCESS <= 1'b0;
         LAST_STATUS  <= '0;
         ERROR        <= 1'b0;
      end else begin
         CANCEL <= cancel_all || end_session;
         ERROR  <= err;
         if (cancel_all) begin
            CARD_ID      <= '0;
            PIN0         <= '0;
            PIN1         <= '0;
            PIN2         <= '0;
            PIN3         <= '0;
            TRANSACTION  <= TXN_NONE;
            AMOUNT       <= '0;
            OKAY         <= 1'b0;
            TRIES_LEFT   <= TRIES_INIT;
            LAST_SUCCESS <= 1'b0;
            LAST_STATUS  <= '0;
         end else begin
            // A rejected session drops the bus but keeps the captured status
            // and the remaining-tries count for the display.
            if (end_session) begin
               CARD_ID     <= '0;
               PIN0        <= '0;
               PIN1        <= '0;
               PIN2        <= '0;
               PIN3        <= '0;
               TRANSACTION <= TXN_NONE;
               AMOUNT      <= '0;
               OKAY        <= 1'b0;
            end
            if (card_accept) begin
               CARD_ID    <= card_buf;
               OKAY       <= 1'b1;
               TRIES_LEFT <= TRIES_INIT;
            end
            if (capture) begin
               LAST_SUCCESS <= SUCCESS;
               LAST_STATUS  <= STATUS;
            end
            if (pin_accept) begin
               PIN0 <= pin_buf[0];
               PIN1 <= pin_buf[1];
               PIN2 <= pin_buf[2];
               PIN3 <= pin_buf[3];
            end
            if (tries_reload)
               TRIES_LEFT <= TRIES_INIT;
            else if (tries_dec)
               TRIES_LEFT <= TRIES_LEFT - 1'b1;
            if (txn_bal)
               TRANSACTION <= TXN_BALANCE;
            else if (amt_accept) begin
               TRANSACTION <= txn_code;
               AMOUNT      <= acc;
            end else if (txn_done)
               TRANSACTION <= TXN_NONE;
         end
      end
   end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Randomized session-level bench for atm_keypad_frontend with a
// scenario model of the expected command-bus behaviour.
module tb_atm_keypad_frontend;
   import atm_fe_pkg::*;

   localparam int MAX_TRIES  = 3;
   localparam int MAX_DIGITS = 9;

   logic        CLK = 1'b0;
   logic        RESET, KEY_VALID, SUCCESS;
   logic [3:0]  KEY_CODE, STATUS;
   logic [3:0]  CARD_ID, PIN0, PIN1, PIN2, PIN3, LAST_STATUS;
   logic [1:0]  TRANSACTION, TRIES_LEFT;
   logic [31:0] AMOUNT;
   logic        OKAY, CANCEL, LAST_SUCCESS, ERROR;
   logic [2:0]  PHASE;

   atm_keypad_frontend dut (
      .CLK(CLK), .RESET(RESET), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
      .SUCCESS(SUCCESS), .STATUS(STATUS), .CARD_ID(CARD_ID), .PIN0(PIN0),
      .PIN1(PIN1), .PIN2(PIN2), .PIN3(PIN3), .TRANSACTION(TRANSACTION),
      .AMOUNT(AMOUNT), .OKAY(OKAY), .CANCEL(CANCEL), .PHASE(PHASE),
      .TRIES_LEFT(TRIES_LEFT), .LAST_SUCCESS(LAST_SUCCESS),
      .LAST_STATUS(LAST_STATUS), .ERROR(ERROR)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Expected state of every output.
   logic [3:0]  e_card, e_last_st;
   logic [3:0]  e_pin [4];
   logic [1:0]  e_txn, e_tries;
   logic [31:0] e_amount;
   logic        e_okay, e_cancel, e_err, e_last_s;
   logic [2:0]  e_phase;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      e_card = 0; e_txn = TXN_NONE; e_amount = 0; e_okay = 0; e_cancel = 0;
      e_err = 0; e_tries = 2'(MAX_TRIES); e_last_s = 0; e_last_st = 0; e_phase = PH_CARD;
      for (int i = 0; i < 4; i++) e_pin[i] = 0;
   endtask

   // Session ends on an ATM rejection: bus dropped, status and tries kept.
   task automatic model_end();
      e_card = 0; e_txn = TXN_NONE; e_amount = 0; e_okay = 0; e_cancel = 1; e_phase = PH_CARD;
      for (int i = 0; i < 4; i++) e_pin[i] = 0;
   endtask

   // Compare all outputs, then expect one-cycle pulses to be gone next time.
   task automatic check_all(input string tag);
      check_val({tag, " phase"}, PHASE, e_phase);
      check_val({tag, " card"}, CARD_ID, e_card);
      check_val({tag, " pin0"}, PIN0, e_pin[0]);
      check_val({tag, " pin1"}, PIN1, e_pin[1]);
      check_val({tag, " pin2"}, PIN2, e_pin[2]);
      check_val({tag, " pin3"}, PIN3, e_pin[3]);
      check_val({tag, " txn"}, TRANSACTION, e_txn);
      check_val({tag, " amount"}, AMOUNT, e_amount);
      check_val({tag, " okay"}, OKAY, e_okay);
      check_val({tag, " cancel"}, CANCEL, e_cancel);
      check_val({tag, " error"}, ERROR, e_err);
      check_val({tag, " tries"}, TRIES_LEFT, e_tries);
      check_val({tag, " last_s"}, LAST_SUCCESS, e_last_s);
      check_val({tag, " last_st"}, LAST_STATUS, e_last_st);
      e_cancel = 0;
      e_err = 0;
   endtask

   task automatic press(input logic [3:0] k);
      KEY_CODE = k; KEY_VALID = 1'b1;
      @(posedge CLK); #1;
      KEY_VALID = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Bring a fresh session to the transaction menu with card 5, PIN 1234.
   task automatic to_txn();
      press(4'd5); check_all("dir card digit");
      SUCCESS = 1; STATUS = 4'h9;
      press(KEY_ENTER);
      e_card = 5; e_okay = 1; e_tries = 2'(MAX_TRIES); e_phase = PH_CARD_WAIT;
      check_all("dir card enter");
      idle(2); e_last_s = 1; e_last_st = 4'h9; e_phase = PH_PIN; check_all("dir card settle");
      for (int i = 0; i < 4; i++) begin press(4'(i + 1)); check_all("dir pin digit"); end
      STATUS = 4'h2;
      press(KEY_ENTER);
      for (int i = 0; i < 4; i++) e_pin[i] = 4'(i + 1);
      e_phase = PH_PIN_WAIT; check_all("dir pin enter");
      idle(2); e_last_st = 4'h2; e_phase = PH_TXN; check_all("dir pin settle");
   endtask

   logic [3:0] c, st, d, pd [4];
   logic       ok, done, dead;
   longint     acc;
   int         cnt, op;

   initial begin
      RESET = 1; KEY_VALID = 0; KEY_CODE = 0; SUCCESS = 0; STATUS = 0;
      repeat (2) @(posedge CLK); #1;
      model_reset(); check_all("reset");
      RESET = 0;
      press(KEY_ENTER); e_err = 1; check_all("card enter empty");

      for (int s = 0; s < 25; s++) begin
         press(4'($urandom_range(0, 9))); check_all("card overwrite");
         c = 4'($urandom_range(0, 9));
         press(c); check_all("card digit");
         ok = ($urandom_range(0, 4) != 0); st = 4'($urandom);
         SUCCESS = ok; STATUS = st;
         press(KEY_ENTER);
         e_card = c; e_okay = 1; e_tries = 2'(MAX_TRIES); e_phase = PH_CARD_WAIT;
         check_all("card enter");
         press(4'($urandom_range(0, 11))); check_all("card wait key ignored");
         idle(1);
         e_last_s = ok; e_last_st = st;
         if (ok) e_phase = PH_PIN; else model_end();
         check_all("card settle");
         if (!ok) begin idle(1); check_all("card reject after"); continue; end

         done = 0; dead = 0;
         while (!done) begin
            cnt = $urandom_range(0, 3);
            for (int i = 0; i < cnt; i++) begin press(4'($urandom_range(0, 9))); check_all("pin short digit"); end
            press(KEY_ENTER); e_err = 1; check_all("pin short enter");
            press(KEY_CLEAR); check_all("pin clear");
            for (int i = 0; i < 4; i++) begin
               pd[i] = 4'($urandom_range(0, 9)); press(pd[i]); check_all("pin digit");
            end
            if ($urandom_range(0, 1)) begin press(4'($urandom_range(0, 9))); e_err = 1; check_all("pin fifth digit"); end
            ok = ($urandom_range(0, 9) < 6); st = 4'($urandom);
            SUCCESS = ok; STATUS = st;
            press(KEY_ENTER);
            for (int i = 0; i < 4; i++) e_pin[i] = pd[i];
            e_phase = PH_PIN_WAIT; check_all("pin enter");
            idle(1); check_all("pin wait");
            idle(1);
            e_last_s = ok; e_last_st = st;
            if (ok) begin
               e_tries = 2'(MAX_TRIES); e_phase = PH_TXN; done = 1;
            end else begin
               e_tries = e_tries - 1;
               if (e_tries == 0) begin model_end(); done = 1; dead = 1; end
               else e_phase = PH_PIN;
            end
            check_all("pin settle");
         end
         if (dead) begin idle(1); check_all("pin exhausted after"); continue; end

         for (int t = 0; t < 4 && !dead; t++) begin
            op = $urandom_range(0, 4);
            ok = $urandom_range(0, 1); st = 4'($urandom);
            SUCCESS = ok; STATUS = st;
            if (op == 0) begin
               press(4'($urandom_range(0, 9))); e_err = 1; check_all("txn digit rejected");
               press(KEY_BALANCE); e_txn = TXN_BALANCE; e_phase = PH_TXN_WAIT; check_all("balance key");
               idle(1); check_all("balance hold");
               idle(1); e_txn = TXN_NONE; e_phase = PH_TXN; e_last_s = ok; e_last_st = st;
               check_all("balance settle");
            end else if (op <= 2) begin
               press(op == 1 ? KEY_WITHDRAW : KEY_DEPOSIT); e_phase = PH_AMT; check_all("amt select");
               acc = 0; cnt = 0;
               for (int i = $urandom_range(1, 11); i > 0; i--) begin
                  d = 4'($urandom_range(0, 9));
                  if (cnt < MAX_DIGITS) begin acc = acc * 10 + d; cnt++; end else e_err = 1;
                  press(d); check_all("amt digit");
                  if ($urandom_range(0, 7) == 0) begin
                     press(KEY_CLEAR); acc = 0; cnt = 0; check_all("amt clear");
                  end
               end
               if (acc == 0) begin
                  press(KEY_ENTER); e_err = 1; check_all("amt zero enter");
                  press(KEY_CLEAR); check_all("amt clear zero");
                  d = 4'($urandom_range(1, 9)); acc = d; press(d); check_all("amt digit");
               end
               press(KEY_ENTER);
               e_amount = 32'(acc); e_txn = (op == 1) ? TXN_WITHDRAW : TXN_DEPOSIT; e_phase = PH_TXN_WAIT;
               check_all("amt enter");
               idle(1); check_all("amt hold");
               idle(1); e_txn = TXN_NONE; e_phase = PH_TXN; e_last_s = ok; e_last_st = st;
               check_all("amt settle");
            end else begin
               press(KEY_CANCEL); model_reset(); e_cancel = 1; check_all("txn cancel");
               idle(1); check_all("txn cancel after");
               dead = 1;
            end
         end
         if (!dead) begin
            press(KEY_CANCEL); model_reset(); e_cancel = 1; check_all("end cancel");
            idle(1); check_all("end cancel after");
         end
      end

      // Ten nines: the tenth digit is refused, amount stays at nine digits.
      to_txn();
      press(KEY_DEPOSIT); e_phase = PH_AMT; check_all("nines select");
      for (int i = 0; i < 10; i++) begin
         if (i == 9) e_err = 1;
         press(4'd9); check_all("nines digit");
      end
      SUCCESS = 1; STATUS = 4'h6;
      press(KEY_ENTER); e_amount = 32'd999999999; e_txn = TXN_DEPOSIT; e_phase = PH_TXN_WAIT;
      check_all("nines enter");
      idle(2); e_txn = TXN_NONE; e_phase = PH_TXN; e_last_st = 4'h6; check_all("nines settle");
      press(KEY_WITHDRAW); e_phase = PH_AMT; check_all("amt reselect");
      press(4'd3); check_all("amt digit before cancel");
      press(KEY_CANCEL); model_reset(); e_cancel = 1; check_all("amt cancel");
      idle(1); check_all("amt cancel after");

      // Reset in the middle of a transaction wait: silent abort.
      to_txn();
      press(KEY_BALANCE); e_txn = TXN_BALANCE; e_phase = PH_TXN_WAIT; check_all("pre-reset balance");
      RESET = 1;
      @(posedge CLK); #1;
      model_reset(); check_all("mid reset");
      RESET = 0;
      idle(1); check_all("after reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
